// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin arbiter feeding a small output FIFO that
// drives a single memory request channel.
//
// Ports:
//   clk          : clock, all state on rising edge
//   reset        : async active-low reset
//   io_req_valid : [N_REQ] per-requestor request valid
//   io_req_ready : [N_REQ] one-hot accept for the granted requestor
//   io_req_bits  : [N_REQ*DATA_W] payloads, requestor i at [i*DATA_W +: DATA_W]
//   io_mem_valid : head FIFO entry valid
//   io_mem_ready : memory accepts head entry
//   io_mem_bits  : [DATA_W] head entry payload
//   io_mem_id    : [ID_W] head entry requestor index
//   io_count     : [log2(DEPTH)+1] FIFO occupancy
module mem_req_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          io_req_valid,
    output logic [N_REQ-1:0]          io_req_ready,
    input  logic [N_REQ*DATA_W-1:0]   io_req_bits,
    output logic                      io_mem_valid,
    input  logic                      io_mem_ready,
    output logic [DATA_W-1:0]         io_mem_bits,
    output logic [ID_W-1:0]           io_mem_id,
    output logic [$clog2(DEPTH):0]    io_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + ID_W;

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [EW-1:0]   fifo_q [DEPTH];

    logic            gnt_vld;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] scan_idx;
    logic            not_full;
    logic            enq;
    logic            deq;
    logic [EW-1:0]   head;
    logic [DATA_W-1:0] gnt_bits;

    // Scan from the highest offset down so the lowest offset from ptr
    // (the highest-priority valid requestor) is the last one written.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = ptr_q + ID_W'(k);
            if (io_req_valid[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    // Ready is a function of registered occupancy only, so memory
    // backpressure never reaches the requestor side combinationally.
    // A full FIFO refuses even when a dequeue happens in the same cycle.
    assign not_full = (count_q < CW'(DEPTH));
    assign enq      = gnt_vld && not_full && reset;
    assign deq      = (count_q != '0) && io_mem_ready;
    assign gnt_bits = io_req_bits[int'(gnt_idx)*DATA_W +: DATA_W];

    always_comb begin
        io_req_ready = '0;
        if (enq) begin
            io_req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            ptr_d    = gnt_idx + ID_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_q[wr_ptr_q] <= {gnt_bits, gnt_idx};
        end
    end

    // Head is masked while empty so stale storage never shows on the port.
    assign head         = fifo_q[rd_ptr_q];
    assign io_mem_valid = (count_q != '0);
    assign io_mem_bits  = io_mem_valid ? head[ID_W +: DATA_W] : '0;
    assign io_mem_id    = io_mem_valid ? head[ID_W-1:0] : '0;
    assign io_count     = count_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Testbench for mem_req_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_mem_req_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int D  = 2;
    localparam int IW = 2;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    io_req_valid;
    logic [N-1:0]    io_req_ready;
    logic [N*DW-1:0] io_req_bits;
    logic            io_mem_valid;
    logic            io_mem_ready;
    logic [DW-1:0]   io_mem_bits;
    logic [IW-1:0]   io_mem_id;
    logic [CW-1:0]   io_count;

    logic [DW-1:0]   req_bits [N];

    int errors = 0;
    int checks = 0;

    // Reference model: priority pointer and a queue of accepted requests.
    int            m_ptr;
    logic [DW-1:0] qb [$];
    int            qi [$];

    always #5 clk = ~clk;

    always_comb begin
        io_req_bits = '0;
        for (int i = 0; i < N; i++) begin
            io_req_bits[i*DW +: DW] = req_bits[i];
        end
    end

    mem_req_arbiter #(
        .N_REQ (N),
        .DATA_W(DW),
        .DEPTH (D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .io_req_valid(io_req_valid),
        .io_req_ready(io_req_ready),
        .io_req_bits (io_req_bits),
        .io_mem_valid(io_mem_valid),
        .io_mem_ready(io_mem_ready),
        .io_mem_bits (io_mem_bits),
        .io_mem_id   (io_mem_id),
        .io_count    (io_count)
    );

    function automatic int m_grant();
        for (int k = 0; k < N; k++) begin
            if (io_req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = m_grant();
        if (g >= 0 && qb.size() < D) r[g] = 1'b1;
        return r;
    endfunction

    // Apply the model's view of the coming edge, then cross it.
    task automatic advance();
        int g;
        bit enq;
        bit deq;
        g   = m_grant();
        enq = (g >= 0) && (qb.size() < D);
        deq = (qb.size() > 0) && io_mem_ready;
        if (deq) begin
            void'(qb.pop_front());
            void'(qi.pop_front());
        end
        if (enq) begin
            qb.push_back(req_bits[g]);
            qi.push_back(g);
            m_ptr = (g + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        qb.delete();
        qi.delete();
        m_ptr = 0;
    endtask

    task automatic apply_reset();
        reset        = 1'b0;
        io_req_valid = '0;
        io_mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        io_req_valid = '1;
        io_mem_ready = 1'b1;
        for (int i = 0; i < N; i++) req_bits[i] = $urandom;
        #2;
        reset = 1'b0;
        #2;
        checks++;
        if (io_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0000", io_req_ready);
        end
        checks++;
        if (io_mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem_valid: got %b want 0", io_mem_valid);
        end
        checks++;
        if (io_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", io_count);
        end
        checks++;
        if (io_mem_bits !== 32'h0 || io_mem_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_mem_out: got %h/%0d want 0/0",
                     io_mem_bits, io_mem_id);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
    endtask

    task automatic test_single();
        apply_reset();
        req_bits[2]  = 32'hA5A5_0002;
        io_req_valid = 4'b0100;
        io_mem_ready = 1'b1;
        #1;
        checks++;
        if (io_req_ready !== 4'b0100 || io_mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: got rdy=%b mv=%b want 0100/0",
                     io_req_ready, io_mem_valid);
        end
        advance();
        io_req_valid = '0;
        #1;
        checks++;
        if (io_mem_valid !== 1'b1 || io_mem_bits !== 32'hA5A5_0002 ||
            io_mem_id !== 2'd2 || io_count !== 2'd1) begin
            errors++;
            $display("FAIL single_out: got v=%b %h id=%0d c=%0d want 1 a5a50002 2 1",
                     io_mem_valid, io_mem_bits, io_mem_id, io_count);
        end
        advance();
        io_req_valid = '1;
        #1;
        checks++;
        if (io_req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL single_ptr: got %b want 1000", io_req_ready);
        end
        advance();
    endtask

    task automatic test_round_robin();
        apply_reset();
        io_req_valid = '1;
        io_mem_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) req_bits[i] = $urandom;
            #1;
            checks++;
            if (io_req_ready !== 4'(1 << (c % 4))) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b want %b",
                         c, io_req_ready, 4'(1 << (c % 4)));
            end
            if (c > 0) begin
                checks++;
                if (io_mem_id !== 2'((c - 1) % 4) || io_count !== 2'd1) begin
                    errors++;
                    $display("FAIL rr_out[%0d]: got id=%0d c=%0d want %0d 1",
                             c, io_mem_id, io_count, (c - 1) % 4);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        io_req_valid = '1;
        io_mem_ready = 1'b0;
        for (int i = 0; i < N; i++) req_bits[i] = 32'h1000_0000 + i;
        #1;
        checks++;
        if (io_req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_acc0: got %b want 0001", io_req_ready);
        end
        advance();
        checks++;
        if (io_req_ready !== 4'b0010 || io_mem_id !== 2'd0) begin
            errors++;
            $display("FAIL bp_acc1: got %b id=%0d want 0010 0",
                     io_req_ready, io_mem_id);
        end
        advance();
        checks++;
        if (io_req_ready !== 4'b0000 || io_count !== 2'd2 ||
            io_mem_id !== 2'd0 || io_mem_bits !== 32'h1000_0000) begin
            errors++;
            $display("FAIL bp_full: got %b c=%0d id=%0d %h want 0000 2 0 10000000",
                     io_req_ready, io_count, io_mem_id, io_mem_bits);
        end
        advance();
        io_mem_ready = 1'b1;
        #1;
        checks++;
        if (io_req_ready !== 4'b0000 || io_mem_id !== 2'd0) begin
            errors++;
            $display("FAIL bp_full_deq: got %b id=%0d want 0000 0",
                     io_req_ready, io_mem_id);
        end
        advance();
        io_mem_ready = 1'b0;
        #1;
        checks++;
        if (io_count !== 2'd1 || io_mem_id !== 2'd1 ||
            io_req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_resume: got c=%0d id=%0d %b want 1 1 0100",
                     io_count, io_mem_id, io_req_ready);
        end
        advance();
    endtask

    task automatic test_simultaneous();
        apply_reset();
        req_bits[0]  = 32'h0000_5A00;
        io_req_valid = 4'b0001;
        io_mem_ready = 1'b0;
        #1;
        advance();
        req_bits[3]  = 32'h3333_0003;
        io_req_valid = 4'b1000;
        io_mem_ready = 1'b1;
        #1;
        checks++;
        if (io_count !== 2'd1 || io_mem_id !== 2'd0 ||
            io_req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL simul_pre: got c=%0d id=%0d %b want 1 0 1000",
                     io_count, io_mem_id, io_req_ready);
        end
        advance();
        io_req_valid = '0;
        io_mem_ready = 1'b0;
        #1;
        checks++;
        if (io_count !== 2'd1 || io_mem_id !== 2'd3 ||
            io_mem_bits !== 32'h3333_0003) begin
            errors++;
            $display("FAIL simul_post: got c=%0d id=%0d %h want 1 3 33330003",
                     io_count, io_mem_id, io_mem_bits);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        io_req_valid = 4'b0011;
        io_mem_ready = 1'b0;
        #1;
        advance();
        advance();
        checks++;
        if (io_count !== 2'd2) begin
            errors++;
            $display("FAIL rmid_fill: got %0d want 2", io_count);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (io_mem_valid !== 1'b0 || io_count !== 2'd0 ||
            io_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rmid_async: got v=%b c=%0d %b want 0 0 0000",
                     io_mem_valid, io_count, io_req_ready);
        end
        model_clear();
        @(posedge clk);
        #1;
        reset        = 1'b1;
        req_bits[1]  = 32'hBEEF_0001;
        io_req_valid = 4'b0010;
        #1;
        checks++;
        if (io_req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rmid_grant: got %b want 0010", io_req_ready);
        end
        advance();
        io_req_valid = '0;
        io_mem_ready = 1'b1;
        #1;
        checks++;
        if (io_mem_valid !== 1'b1 || io_mem_id !== 2'd1 ||
            io_mem_bits !== 32'hBEEF_0001 || io_count !== 2'd1) begin
            errors++;
            $display("FAIL rmid_out: got v=%b id=%0d %h c=%0d want 1 1 beef0001 1",
                     io_mem_valid, io_mem_id, io_mem_bits, io_count);
        end
        advance();
        checks++;
        if (io_mem_valid !== 1'b0 || io_count !== 2'd0) begin
            errors++;
            $display("FAIL rmid_stale: got v=%b c=%0d want 0 0",
                     io_mem_valid, io_count);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] pb;
        int            pid;
        apply_reset();
        io_mem_ready = 1'b1;
        pb  = '0;
        pid = 0;
        for (int i = 0; i <= 7; i++) begin
            int id;
            id = $urandom_range(0, N - 1);
            if (i < 7) begin
                req_bits[id] = $urandom;
                io_req_valid = 4'(1 << id);
            end else begin
                io_req_valid = '0;
            end
            #1;
            if (i < 7) begin
                checks++;
                if (io_req_ready !== io_req_valid) begin
                    errors++;
                    $display("FAIL wrap_acc[%0d]: got %b want %b",
                             i, io_req_ready, io_req_valid);
                end
            end
            if (i > 0) begin
                checks++;
                if (io_mem_valid !== 1'b1 || io_mem_bits !== pb ||
                    io_mem_id !== 2'(pid) || io_count !== 2'd1) begin
                    errors++;
                    $display("FAIL wrap_out[%0d]: got v=%b %h id=%0d c=%0d want 1 %h %0d 1",
                             i, io_mem_valid, io_mem_bits, io_mem_id,
                             io_count, pb, pid);
                end
            end
            pb  = req_bits[id];
            pid = id;
            advance();
        end
        checks++;
        if (io_mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_drain: got v=%b want 0", io_mem_valid);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            io_req_valid = 4'($urandom);
            io_mem_ready = ($urandom_range(0, 99) < (k < 200 ? 30 : 80));
            for (int i = 0; i < N; i++) req_bits[i] = $urandom;
            #1;
            checks++;
            if (io_req_ready !== m_ready()) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b want %b",
                         k, io_req_ready, m_ready());
            end
            checks++;
            if (io_mem_valid !== (qb.size() != 0) ||
                io_count !== CW'(qb.size())) begin
                errors++;
                $display("FAIL rand_occ[%0d]: got v=%b c=%0d want c=%0d",
                         k, io_mem_valid, io_count, qb.size());
            end
            if (qb.size() != 0) begin
                checks++;
                if (io_mem_bits !== qb[0] || io_mem_id !== IW'(qi[0])) begin
                    errors++;
                    $display("FAIL rand_head[%0d]: got %h/%0d want %h/%0d",
                             k, io_mem_bits, io_mem_id, qb[0], qi[0]);
                end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Round-robin arbiter with a small output buffer between N requestor request channels and the single memory request channel.
- Consumes the per-requestor req valid/ready/bits bundles that the requestor-vector stage exposes.
- Forwards one request per cycle, tagged with the winning requestor index, to the memory port.
- Buffering isolates memory backpressure, so there is no combinational path from io_mem_ready to any io_req_ready.

Parameters:
- N_REQ, 4, number of requestors (power of two, 2..8)
- DATA_W, 32, request payload width
- DEPTH, 2, output FIFO entries (power of two, >=2)
- ID_W, log2(N_REQ), width of requestor tag

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0); deassertion synchronous to clk
- io_req_valid  in  N_REQ  bit i: requestor i has a request
- io_req_ready  out  N_REQ  bit i: requestor i's request accepted this cycle when valid
- io_req_bits  in  N_REQ*DATA_W  payload; requestor i occupies bits [i*DATA_W +: DATA_W]
- io_mem_valid  out  1  head FIFO entry valid
- io_mem_ready  in  1  memory accepts head entry
- io_mem_bits  out  DATA_W  head entry payload
- io_mem_id  out  ID_W  head entry requestor index
- io_count  out  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- State:
  - ptr (ID_W): round-robin priority pointer.
  - FIFO storage: DEPTH x (DATA_W+ID_W).
  - wr_ptr, rd_ptr: log2(DEPTH) each, wrapping modulo DEPTH.
  - count: 0..DEPTH.
- Reset (reset==0, any time, including mid-transfer):
  - ptr=0, wr_ptr=0, rd_ptr=0, count=0.
  - io_mem_valid=0, io_mem_bits=0, io_mem_id=0, io_count=0.
  - io_req_ready forced to all-zero while reset is asserted.
  - In-flight FIFO contents are discarded; storage contents need not be cleared.
- Grant (combinational):
  - Scan indices ptr, ptr+1, ..., ptr+N_REQ-1 (mod N_REQ).
  - Winner g = first index with io_req_valid set.
  - No valid requestor: no grant.
- io_req_ready[i] = (i==g) && (count<DEPTH) && reset deasserted.
  - At most one bit is set.
  - Depends only on io_req_valid, ptr and count, never on io_mem_ready.
- Enqueue:
  - Occurs when a grant exists and count<DEPTH.
  - Writes {io_req_bits[g], g} at wr_ptr, advances wr_ptr, and sets ptr <= g+1 mod N_REQ.
- No grant or FIFO full: ptr holds.
- Dequeue:
  - Occurs when io_mem_valid && io_mem_ready.
  - Advances rd_ptr.
- Outputs from FIFO state:
  - io_mem_valid = (count!=0).
  - io_mem_bits and io_mem_id = head entry, driven from registered FIFO state.
- Latency: a request accepted in cycle t is visible on io_mem in cycle t+1 at the earliest.
- Throughput: one enqueue and one dequeue per cycle.
- count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged on both or neither.
- Full (count==DEPTH):
  - No enqueue, even if a dequeue happens in the same cycle (registered-ready policy).
  - Enqueue resumes the cycle after count drops.
- Empty (count==0):
  - io_mem_valid=0 and io_mem_ready is ignored.
  - No bypass: enqueue and output are never in the same cycle.
- Requestor rules:
  - A requestor may drop valid before acceptance; the arbiter keeps no lock.
  - Payload is sampled only on the enqueue edge.
- io_mem_bits and io_mem_id are stable while io_mem_valid && !io_mem_ready.
- Pointer wrap: wr_ptr, rd_ptr and ptr wrap naturally at their width; no special case.

Test Plan:
- Single requestor: reset released, io_req_valid=4'b0100, bits[2]=0xA5A5_0002, mem_ready=1 -> io_req_ready=4'b0100 in cycle 0; next cycle io_mem_valid=1, bits=0xA5A5_0002, id=2; ptr becomes 3.
- Round-robin: all four valid continuously, mem_ready=1 -> accepted ids in order 0,1,2,3,0,1; each requestor granted exactly once per 4 cycles; io_count stays 1.
- Backpressure: all valid, mem_ready=0 -> two accepts (ids 0,1), then io_req_ready=0, io_count=2, and io_mem_id=0 held stable. Raise mem_ready for one cycle -> id 0 dequeued, no enqueue that cycle; next cycle id 2 accepted.
- Simultaneous enqueue/dequeue: count=1, requestor 3 valid, mem_ready=1 -> head dequeued, id 3 enqueued in the same cycle, count stays 1; id 3 appears next cycle.
- Reset mid-operation: FIFO holding 2 entries, reset driven 0 asynchronously between edges -> io_mem_valid=0 and io_count=0 immediately, io_req_ready=0. After release, requestor 1 alone valid -> granted first with ptr=0 priority; old entries never reappear.
- Wrap: DEPTH=2, issue 7 single requests with mem_ready=1 -> all seven emerge in order with correct bits and ids; no loss or duplication across the wr_ptr/rd_ptr wrap.
